// File: rtl/med_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : med_pkg
//  Purpose  : Shared types and constants for the median sequencer slice.
//  Revision : 1.0  initial release
// ============================================================================
package med_pkg;

   // Default geometry: 8-bit samples, 9-sample window
   localparam int DEF_WIDTH = 8;
   localparam int DEF_NUM   = 9;

   // Derived constants for the default window
   localparam int P       = (DEF_NUM + 1) / 2;
   localparam int CMP_CYC = DEF_NUM - 1;
   localparam int CNT_W   = $clog2(DEF_NUM + 1);

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_CMP  = 3'd2,
      ST_DISC = 3'd3,
      ST_HOLD = 3'd4
   } med_state_t;

   // Number of compare passes for an arbitrary odd window size
   function automatic int med_passes(input int num);
      return (num + 1) / 2;
   endfunction

   // Counter width able to hold 0..num
   function automatic int med_cnt_w(input int num);
      return $clog2(num + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/MED.sv
`default_nettype none
// ============================================================================
//  Module   : MED
//  Purpose  : Compare-exchange ring. Shifts on every clock. The tail slot
//             (DO) keeps the larger of itself and its neighbour while the
//             smaller value re-enters at the head; BYP turns the tail into a
//             plain shift, and DSI replaces the head value with DI.
//  Revision : 1.0  initial release
// ============================================================================
module MED #(
   parameter int WIDTH = 8,
   parameter int NUM   = 9
) (
   input  logic             CLK,
   input  logic [WIDTH-1:0] DI,
   input  logic             DSI,
   input  logic             BYP,
   output logic [WIDTH-1:0] DO
);

   logic [WIDTH-1:0] r_ring [NUM];
   logic [WIDTH-1:0] w_max;
   logic [WIDTH-1:0] w_min;
   logic [WIDTH-1:0] w_head;

   // Tail compare-exchange and head selection
   always_comb begin
      w_max  = (r_ring[NUM-1] > r_ring[NUM-2]) ? r_ring[NUM-1] : r_ring[NUM-2];
      w_min  = (r_ring[NUM-1] > r_ring[NUM-2]) ? r_ring[NUM-2] : r_ring[NUM-1];
      w_head = DSI ? DI : (BYP ? r_ring[NUM-1] : w_min);
   end

   // Ring shift every clock
   always_ff @(posedge CLK) begin
      r_ring[0] <= w_head;
      for (int i = 1; i < NUM - 1; i++) begin
         r_ring[i] <= r_ring[i-1];
      end
      r_ring[NUM-1] <= BYP ? r_ring[NUM-2] : w_max;
   end

   assign DO = r_ring[NUM-1];

endmodule
`default_nettype wire

// File: rtl/med_win_buf.sv
`default_nettype none
// ============================================================================
//  Module   : med_win_buf
//  Purpose  : Window gather buffer. Samples are written in arrival order at
//             the current count; a read port indexes the stored window, and a
//             clear rewinds the count once the window has been loaded.
//  Revision : 1.0  initial release
// ============================================================================
module med_win_buf
   import med_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NUM   = DEF_NUM,
   parameter int CNT_W = med_cnt_w(NUM)
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_clr,
   input  logic [CNT_W-1:0] i_rd_idx,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full
);

   localparam logic [CNT_W-1:0] c_num = CNT_W'(NUM);

   logic [WIDTH-1:0] r_mem [NUM];
   logic [CNT_W-1:0] r_wcnt;

   // Write count: clear wins, otherwise advance on each accepted beat
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_wcnt <= '0;
      end else if (i_clr) begin
         r_wcnt <= '0;
      end else if (i_wr_en) begin
         r_wcnt <= r_wcnt + 1'b1;
      end
   end

   // Sample storage; contents need no reset because the count gates use
   always_ff @(posedge CLK) begin
      if (i_wr_en) begin
         r_mem[r_wcnt] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_idx];
   assign o_full    = (r_wcnt == c_num);

endmodule
`default_nettype wire

// File: rtl/med_seq.sv
`default_nettype none
// ============================================================================
//  Module   : med_seq
//  Purpose  : Sequencer for the MED compare-exchange ring. Gathers a window
//             of samples, loads it into the ring, alternates compare passes
//             with max discards until the ring max is the median, then
//             presents that median on a valid/ready output.
//  Revision : 1.0  initial release
// ============================================================================
module med_seq
   import med_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NUM   = DEF_NUM
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [WIDTH-1:0] S_DATA,
   input  logic             S_VALID,
   output logic             S_READY,
   output logic [WIDTH-1:0] M_DATA,
   output logic             M_VALID,
   input  logic             M_READY,
   output logic [WIDTH-1:0] MED_DI,
   output logic             MED_DSI,
   output logic             MED_BYP,
   input  logic [WIDTH-1:0] MED_DO
);

   localparam int C_PASSES = med_passes(NUM);
   localparam int C_CMP_CYC = NUM - 1;
   localparam int C_CNT_W  = med_cnt_w(NUM);

   localparam logic [C_CNT_W-1:0] c_load_last = C_CNT_W'(NUM - 1);
   localparam logic [C_CNT_W-1:0] c_cmp_last  = C_CNT_W'(C_CMP_CYC - 1);
   localparam logic [C_CNT_W-1:0] c_pass_last = C_CNT_W'(C_PASSES - 1);

   med_state_t         r_state;
   logic [C_CNT_W-1:0] r_lcnt;
   logic [C_CNT_W-1:0] r_ccnt;
   logic [C_CNT_W-1:0] r_pass;
   logic [WIDTH-1:0]   r_m_data;
   logic               r_m_valid;

   logic               w_full;
   logic               w_wr_en;
   logic               w_clr;
   logic [WIDTH-1:0]   w_rd_data;

   // Input is held off while the buffer is being read into the ring
   assign S_READY = !w_full && (r_state != ST_LOAD);
   assign w_wr_en = S_VALID && S_READY;
   assign w_clr   = (r_state == ST_LOAD) && (r_lcnt == c_load_last);

   med_win_buf #(
      .WIDTH (WIDTH),
      .NUM   (NUM),
      .CNT_W (C_CNT_W)
   ) u_buf (
      .CLK       (CLK),
      .nRST      (nRST),
      .i_wr_en   (w_wr_en),
      .i_wr_data (S_DATA),
      .i_clr     (w_clr),
      .i_rd_idx  (r_lcnt),
      .o_rd_data (w_rd_data),
      .o_full    (w_full)
   );

   // Ring drive decoded from state; outside LOAD/DISC the ring only re-compares
   always_comb begin
      MED_DI  = '0;
      MED_DSI = 1'b0;
      MED_BYP = 1'b0;
      case (r_state)
         ST_LOAD: begin
            MED_DI  = w_rd_data;
            MED_DSI = 1'b1;
            MED_BYP = 1'b1;
         end
         ST_DISC: begin
            MED_DSI = 1'b1;
            MED_BYP = 1'b1;
         end
         default: ;
      endcase
   end

   // Sequencer FSM and result register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state   <= ST_IDLE;
         r_lcnt    <= '0;
         r_ccnt    <= '0;
         r_pass    <= '0;
         r_m_data  <= '0;
         r_m_valid <= 1'b0;
      end else begin
         // Consumption clears valid; a capture below in the same cycle overrides
         if (M_READY) begin
            r_m_valid <= 1'b0;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_full) begin
                  r_state <= ST_LOAD;
                  r_lcnt  <= '0;
               end
            end
            ST_LOAD: begin
               if (r_lcnt == c_load_last) begin
                  r_state <= ST_CMP;
                  r_lcnt  <= '0;
                  r_ccnt  <= '0;
                  r_pass  <= '0;
               end else begin
                  r_lcnt <= r_lcnt + 1'b1;
               end
            end
            ST_CMP: begin
               if (r_ccnt == c_cmp_last) begin
                  r_ccnt  <= '0;
                  r_state <= (r_pass == c_pass_last) ? ST_HOLD : ST_DISC;
               end else begin
                  r_ccnt <= r_ccnt + 1'b1;
               end
            end
            ST_DISC: begin
               r_pass  <= r_pass + 1'b1;
               r_state <= ST_CMP;
            end
            ST_HOLD: begin
               // The ring keeps re-comparing, so DO stays the median while stalled
               if (!r_m_valid || M_READY) begin
                  r_m_data  <= MED_DO;
                  r_m_valid <= 1'b1;
                  r_lcnt    <= '0;
                  r_state   <= w_full ? ST_LOAD : ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign M_DATA  = r_m_data;
   assign M_VALID = r_m_valid;

endmodule
`default_nettype wire
